logic_sweep_checker: RTL and testbench

//  On-chip exhaustive checker for the 4-input gate y = ~a & (~(b&c) | d).

---
 rtl/logic_sweep_checker_if.sv | 27 ++
 rtl/logic_sweep_checker.sv | 131 +++++++++++++
 tb/tb_logic_sweep_checker.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_sweep_checker_if.sv
// Stimulus/response bundle between the sweep checker (master) and the gate plus host side (slave).
interface logic_sweep_checker_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             y_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic             fail_valid;
  logic [3:0]       fail_vec;

  modport master (
    input  start, y_in,
    output a, b, c, d, busy, done, pass, err_cnt, fail_valid, fail_vec
  );

  modport slave (
    output start, y_in,
    input  a, b, c, d, busy, done, pass, err_cnt, fail_valid, fail_vec
  );
endinterface

// File: rtl/logic_sweep_checker.sv
// Exhaustive 16-vector checker for y = ~a & (~(b&c) | d); done 16*DWELL+1 cycles after start, start ignored while busy.
// Optional CHK_STOP_ON_FAIL_EN: halt in DONE on the first mismatch, holding the failing vector on a..d.
module logic_sweep_checker #(
  parameter int DWELL  = 4,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  logic_sweep_checker_if.master bus
);

  localparam int                 CNT_W    = $clog2(DWELL);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0]   CNT_SMP  = CNT_W'(SETTLE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             fail_valid_q, fail_valid_d;
  logic [3:0]       fail_vec_q, fail_vec_d;
  logic             pass_q, pass_d;

  logic exp_y;
  logic sample;
  logic mismatch;
  logic last_slot;

  assign exp_y     = ~vec_q[3] & (~(vec_q[2] & vec_q[1]) | vec_q[0]);
  assign sample    = (state_q == RUN) && (cnt_q == CNT_SMP);
  assign mismatch  = sample && (bus.y_in != exp_y);
  assign last_slot = (cnt_q == CNT_LAST) && (vec_q == 4'hF);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      cnt_q        <= '0;
      err_cnt_q    <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      err_cnt_q    <= err_cnt_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      pass_q       <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
`ifdef CHK_STOP_ON_FAIL_EN
        if (mismatch || last_slot) state_d = DONE;
`else
        if (last_slot) state_d = DONE;
`endif
      end
      DONE: if (bus.start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Datapath; vec wraps 15 -> 0 on its own, which is the DONE value in full-sweep mode.
  always_comb begin
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    err_cnt_d    = err_cnt_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    pass_d       = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          vec_d        = '0;
          cnt_d        = '0;
          err_cnt_d    = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          pass_d       = 1'b0;
        end
      end
      RUN: begin
        if (mismatch) begin
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec_q;
          end
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          vec_d = vec_q + 4'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`ifdef CHK_STOP_ON_FAIL_EN
        if (mismatch) begin
          vec_d = vec_q;
          cnt_d = '0;
        end
`endif
        if (state_d == DONE) pass_d = (err_cnt_d == '0);
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.busy       = (state_q == RUN);
    bus.done       = (state_q == DONE);
    bus.pass       = pass_q;
    bus.err_cnt    = err_cnt_q;
    bus.fail_valid = fail_valid_q;
    bus.fail_vec   = fail_vec_q;
    bus.a          = vec_q[3];
    bus.b          = vec_q[2];
    bus.c          = vec_q[1];
    bus.d          = vec_q[0];
  end

endmodule

// File: tb/tb_logic_sweep_checker.sv
// Directed bench for logic_sweep_checker: main instance (ERR_W=8) driven by a selectable gate model,
// second instance (ERR_W=2) fed y_in stuck at 1 to exercise counter saturation.
module tb_logic_sweep_checker;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mode;
  logic [3:0] v;
  logic gate;

  always #5 clk = ~clk;

  logic_sweep_checker_if #(.ERR_W(8)) bus();
  logic_sweep_checker_if #(.ERR_W(2)) bus2();

  logic_sweep_checker #(.DWELL(4), .SETTLE(2), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  logic_sweep_checker #(.DWELL(4), .SETTLE(2), .ERR_W(2)) dut_small (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  assign bus2.start = bus.start;
  assign bus2.y_in  = 1'b1;

  // Gate model: 0 good, 1 stuck-0, 2 stuck-1, 3 good but wrong on vectors 9 and 13
  always_comb begin
    v    = {bus.a, bus.b, bus.c, bus.d};
    gate = ~v[3] & (~(v[2] & v[1]) | v[0]);
    bus.y_in = gate;
    case (mode)
      1:       bus.y_in = 1'b0;
      2:       bus.y_in = 1'b1;
      3:       bus.y_in = gate ^ ((v == 4'd9) || (v == 4'd13));
      default: bus.y_in = gate;
    endcase
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    mode = 0;
    tick(2);
    rst = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.done, bus.pass, bus.fail_valid} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {bus.busy, bus.done, bus.pass, bus.fail_valid});
    end
    n_cmp++;
    if (bus.err_cnt !== 8'd0) begin
      n_bad++; $display("FAIL reset_err_cnt: got %0d want 0", bus.err_cnt);
    end
    n_cmp++;
    if ({bus.a, bus.b, bus.c, bus.d, bus.fail_vec} !== 8'h00) begin
      n_bad++; $display("FAIL reset_vec: got abcd=%h fail_vec=%h want 0/0", {bus.a, bus.b, bus.c, bus.d}, bus.fail_vec);
    end
  endtask

  task automatic test_clean_sweep();
    mode = 0;
    pulse_start();
    n_cmp++;
    if ({bus.busy, bus.done, bus.a, bus.b, bus.c, bus.d} !== 6'b100000) begin
      n_bad++; $display("FAIL clean_first: got busy/done/abcd=%b want 100000", {bus.busy, bus.done, bus.a, bus.b, bus.c, bus.d});
    end
    tick(20);
    n_cmp++;
    if ({bus.a, bus.b, bus.c, bus.d} !== 4'd5) begin
      n_bad++; $display("FAIL clean_vec5: got %h want 5", {bus.a, bus.b, bus.c, bus.d});
    end
    tick(43);
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      n_bad++; $display("FAIL clean_pre_done: got busy/done=%b want 10", {bus.busy, bus.done});
    end
    tick(1);
    n_cmp++;
    if ({bus.busy, bus.done, bus.pass, bus.fail_valid} !== 4'b0110) begin
      n_bad++; $display("FAIL clean_done: got busy/done/pass/fv=%b want 0110", {bus.busy, bus.done, bus.pass, bus.fail_valid});
    end
    n_cmp++;
    if (bus.err_cnt !== 8'd0) begin
      n_bad++; $display("FAIL clean_err: got %0d want 0", bus.err_cnt);
    end
    n_cmp++;
    if ({bus.a, bus.b, bus.c, bus.d} !== 4'd0) begin
      n_bad++; $display("FAIL clean_abcd_done: got %h want 0", {bus.a, bus.b, bus.c, bus.d});
    end
  endtask

  task automatic test_err_saturate();
    pulse_start();
`ifdef CHK_STOP_ON_FAIL_EN
    tick(40);
    n_cmp++;
    if ({bus2.done, bus2.pass, bus2.err_cnt} !== 4'b1001) begin
      n_bad++; $display("FAIL small_stop: got done/pass/err=%b want 1001", {bus2.done, bus2.pass, bus2.err_cnt});
    end
    tick(24);
`else
    tick(64);
    n_cmp++;
    if ({bus2.done, bus2.pass, bus2.err_cnt} !== 4'b1011) begin
      n_bad++; $display("FAIL small_saturate: got done/pass/err=%b want 1011", {bus2.done, bus2.pass, bus2.err_cnt});
    end
`endif
  endtask

`ifndef CHK_STOP_ON_FAIL_EN
  task automatic test_stuck();
    mode = 1;
    pulse_start();
    tick(64);
    n_cmp++;
    if (bus.err_cnt !== 8'd7) begin
      n_bad++; $display("FAIL stuck0_err: got %0d want 7", bus.err_cnt);
    end
    n_cmp++;
    if ({bus.done, bus.pass, bus.fail_valid, bus.fail_vec} !== 7'b1010000) begin
      n_bad++; $display("FAIL stuck0_flags: got done/pass/fv/fvec=%b want 1010000", {bus.done, bus.pass, bus.fail_valid, bus.fail_vec});
    end
    mode = 2;
    pulse_start();
    n_cmp++;
    if ({bus.busy, bus.done, bus.fail_valid, bus.err_cnt} !== 11'b10000000000) begin
      n_bad++; $display("FAIL restart_clear: got busy/done/fv/err=%b want 10000000000", {bus.busy, bus.done, bus.fail_valid, bus.err_cnt});
    end
    tick(64);
    n_cmp++;
    if (bus.err_cnt !== 8'd9) begin
      n_bad++; $display("FAIL stuck1_err: got %0d want 9", bus.err_cnt);
    end
    n_cmp++;
    if ({bus.done, bus.pass, bus.fail_valid, bus.fail_vec} !== 7'b1010110) begin
      n_bad++; $display("FAIL stuck1_flags: got done/pass/fv/fvec=%b want 1010110", {bus.done, bus.pass, bus.fail_valid, bus.fail_vec});
    end
  endtask

  task automatic test_faulty_gate();
    mode = 3;
    pulse_start();
    tick(64);
    n_cmp++;
    if (bus.err_cnt !== 8'd2) begin
      n_bad++; $display("FAIL faulty_err: got %0d want 2", bus.err_cnt);
    end
    n_cmp++;
    if ({bus.pass, bus.fail_valid, bus.fail_vec} !== 6'b011001) begin
      n_bad++; $display("FAIL faulty_vec: got pass/fv/fvec=%b want 011001", {bus.pass, bus.fail_valid, bus.fail_vec});
    end
  endtask
`endif

  task automatic test_reset_mid();
    mode = 0;
    pulse_start();
    tick(21);
    n_cmp++;
    if ({bus.busy, bus.a, bus.b, bus.c, bus.d} !== 5'b10101) begin
      n_bad++; $display("FAIL mid_vec5: got busy/abcd=%b want 10101", {bus.busy, bus.a, bus.b, bus.c, bus.d});
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.done, bus.pass, bus.fail_valid, bus.a, bus.b, bus.c, bus.d} !== 8'h00) begin
      n_bad++; $display("FAIL mid_reset: got %b want 00000000", {bus.busy, bus.done, bus.pass, bus.fail_valid, bus.a, bus.b, bus.c, bus.d});
    end
    tick(3);
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_bad++; $display("FAIL mid_idle: got busy/done=%b want 00", {bus.busy, bus.done});
    end
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_over_start: got busy=%b want 0", bus.busy);
    end
    pulse_start();
    tick(64);
    n_cmp++;
    if ({bus.done, bus.pass, bus.err_cnt} !== 10'b1100000000) begin
      n_bad++; $display("FAIL post_reset_sweep: got done/pass/err=%b want 1100000000", {bus.done, bus.pass, bus.err_cnt});
    end
  endtask

  task automatic test_restart_ignored();
    mode = 0;
    pulse_start();
    tick(32);
    pulse_start();
    n_cmp++;
    if ({bus.busy, bus.a, bus.b, bus.c, bus.d} !== 5'b11000) begin
      n_bad++; $display("FAIL ignore_vec8: got busy/abcd=%b want 11000", {bus.busy, bus.a, bus.b, bus.c, bus.d});
    end
    tick(30);
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      n_bad++; $display("FAIL ignore_pre_done: got busy/done=%b want 10", {bus.busy, bus.done});
    end
    tick(1);
    n_cmp++;
    if ({bus.busy, bus.done, bus.pass} !== 3'b011) begin
      n_bad++; $display("FAIL ignore_done: got busy/done/pass=%b want 011", {bus.busy, bus.done, bus.pass});
    end
  endtask

`ifdef CHK_STOP_ON_FAIL_EN
  task automatic test_stop_on_fail();
    mode = 2;
    pulse_start();
    tick(26);
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      n_bad++; $display("FAIL stop_pre: got busy/done=%b want 10", {bus.busy, bus.done});
    end
    tick(1);
    n_cmp++;
    if ({bus.done, bus.pass, bus.err_cnt} !== 10'b1000000001) begin
      n_bad++; $display("FAIL stop_done: got done/pass/err=%b want 1000000001", {bus.done, bus.pass, bus.err_cnt});
    end
    n_cmp++;
    if ({bus.a, bus.b, bus.c, bus.d, bus.fail_vec} !== 8'h66) begin
      n_bad++; $display("FAIL stop_vec: got abcd/fvec=%h want 66", {bus.a, bus.b, bus.c, bus.d, bus.fail_vec});
    end
    tick(10);
    n_cmp++;
    if ({bus.done, bus.a, bus.b, bus.c, bus.d} !== 5'b10110) begin
      n_bad++; $display("FAIL stop_hold: got done/abcd=%b want 10110", {bus.done, bus.a, bus.b, bus.c, bus.d});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_sweep();
    test_err_saturate();
`ifndef CHK_STOP_ON_FAIL_EN
    test_stuck();
    test_faulty_gate();
`else
    test_stop_on_fail();
`endif
    test_reset_mid();
    test_restart_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
